frame_stats: RTL and testbench
==============================

FRAME_STATS -- requirements
Module: frame_stats

Interface
REQ-001 Parameter WIDTH, default 36, sample width in bits (signed two's complement).
REQ-002 Parameter DEPTH, default 16, samples per frame (power of two, >= 2).
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), frame index width.
REQ-004 Parameter SUM_WIDTH, default WIDTH+ADDR_WIDTH, accumulator width.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 frame_start_i  input  1  single-cycle pulse marking that a new DEPTH-sample frame is readable upstream.
REQ-008 sample_i  input  WIDTH signed  frame sample.
REQ-009 sample_valid_i  input  1  sample_i valid.
REQ-010 sample_ready_o  output  1  block accepts a sample this cycle.
REQ-011 sum_o  output  SUM_WIDTH signed  sum of the last completed frame.
REQ-012 peak_o  output  WIDTH unsigned  maximum absolute sample value of the last completed frame.
REQ-013 result_valid_o  output  1  sum_o/peak_o hold a result not yet consumed.
REQ-014 result_ready_i  input  1  downstream consumes the result.
REQ-015 busy_o  output  1  high whenever state is not IDLE.
REQ-016 frame_drop_o  output  1  one-cycle pulse: a frame_start_i was ignored.
REQ-017 sample_count_o  output  ADDR_WIDTH+1  samples accepted in the current frame.

Function
REQ-018 States: IDLE=2'd0, COLLECT=2'd1, RESULT=2'd2; any other encoding SHALL go to IDLE next cycle.
REQ-019 Sample accept = sample_valid_i && sample_ready_o; result accept = result_valid_o && result_ready_i.
REQ-020 sample_ready_o SHALL be 1 only in COLLECT, combinationally from state.
REQ-021 IDLE: frame_start_i=1 -> COLLECT next cycle, count, running sum and running peak cleared to 0 on that edge; sample_valid_i ignored in IDLE.
REQ-022 COLLECT, each sample accept: running sum += sign-extended sample_i; running peak = max(running peak, |sample_i|); count += 1.
REQ-023 |x| computed in WIDTH unsigned bits; |-2^(WIDTH-1)| SHALL equal 2^(WIDTH-1) with no wrap.
REQ-024 SUM_WIDTH SHALL hold DEPTH full-scale samples of either sign without overflow; no saturation logic.
REQ-025 Accept with count == DEPTH-1 -> next cycle: state RESULT, sum_o/peak_o loaded with the final totals including that sample, result_valid_o=1, count = DEPTH.
REQ-026 Latency: result_valid_o rises exactly one cycle after the DEPTH-th sample accept.
REQ-027 RESULT: result_valid_o held at 1, sum_o/peak_o stable until result accept; on accept -> IDLE next cycle, result_valid_o=0, count=0.
REQ-028 sum_o/peak_o SHALL keep their last value after consumption until the next frame completes.
REQ-029 frame_start_i in COLLECT or RESULT SHALL be ignored and produce frame_drop_o=1 on the next cycle only; current frame unaffected.
REQ-030 frame_start_i and result accept in the same RESULT cycle: result consumed, start ignored, frame_drop_o pulses.
REQ-031 sample_valid_i gaps in COLLECT SHALL stall the frame indefinitely without state change.
REQ-032 busy_o = (state != IDLE); sample_count_o = registered count.

Reset
REQ-033 rst_i=1 at a rising edge SHALL force: state IDLE, sample_ready_o=0, sum_o=0, peak_o=0, result_valid_o=0, busy_o=0, frame_drop_o=0, sample_count_o=0, running sum/peak=0.
REQ-034 Reset SHALL take priority over all inputs, including mid-COLLECT and mid-RESULT; the partial frame is discarded.

Verification
REQ-035 Reset, then idle 10 cycles -> all outputs 0, sample_ready_o=0.
REQ-036 Pulse start, then 16 back-to-back samples 1..16 -> one cycle after the 16th accept: result_valid_o=1, sum_o=136, peak_o=16, sample_count_o=16.
REQ-037 Frame of one sample -2^35 and fifteen 0s, with valid gaps -> sum_o=-2^35, peak_o=36'h8_0000_0000.
REQ-038 16 samples of 2^35-1 -> sum_o=2^39-16 (positive, no overflow), peak_o=2^35-1.
REQ-039 Hold result_ready_i=0 for 5 cycles in RESULT and pulse frame_start_i at cycle 2 -> result_valid_o and outputs stable; frame_drop_o=1 for exactly one cycle; state stays RESULT; result_ready_i=1 -> IDLE next cycle.
REQ-040 Assert rst_i after 7 accepted samples -> IDLE, sample_count_o=0; next full frame of 1..16 yields sum_o=136, peak_o=16.

Source files
------------

// File: rtl/frame_stats.sv
// Frame statistics: accumulates a DEPTH-sample frame into a signed sum and
// a peak absolute value, then holds the result until downstream takes it.
module frame_stats #(
  parameter int WIDTH      = 36,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SUM_WIDTH  = WIDTH + ADDR_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        frame_start_i,
  input  logic signed [WIDTH-1:0]     sample_i,
  input  logic                        sample_valid_i,
  output logic                        sample_ready_o,
  output logic signed [SUM_WIDTH-1:0] sum_o,
  output logic        [WIDTH-1:0]     peak_o,
  output logic                        result_valid_o,
  input  logic                        result_ready_i,
  output logic                        busy_o,
  output logic                        frame_drop_o,
  output logic        [ADDR_WIDTH:0]  sample_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic signed [SUM_WIDTH-1:0] acc_sum_q, acc_sum_d;
  logic [WIDTH-1:0]       acc_peak_q, acc_peak_d;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]       peak_q, peak_d;
  logic                   drop_q, drop_d;

  logic [WIDTH-1:0]            abs_s;
  logic signed [SUM_WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0]            peak_nxt;

  // Negating the most negative value yields 2^(WIDTH-1) read as unsigned.
  always_comb begin
    abs_s = sample_i[WIDTH-1] ? $unsigned(-sample_i)
                              : $unsigned(sample_i);
    sum_nxt  = acc_sum_q + SUM_WIDTH'(sample_i);
    peak_nxt = (abs_s > acc_peak_q) ? abs_s : acc_peak_q;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_sum_d  = acc_sum_q;
    acc_peak_d = acc_peak_q;
    sum_d      = sum_q;
    peak_d     = peak_q;
    drop_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d    = COLLECT;
          count_d    = '0;
          acc_sum_d  = '0;
          acc_peak_d = '0;
        end
      end
      COLLECT: begin
        drop_d = frame_start_i;
        if (sample_valid_i) begin
          acc_sum_d  = sum_nxt;
          acc_peak_d = peak_nxt;
          count_d    = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = RESULT;
            sum_d   = sum_nxt;
            peak_d  = peak_nxt;
          end
        end
      end
      RESULT: begin
        drop_d = frame_start_i;
        if (result_ready_i) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_sum_q  <= '0;
      acc_peak_q <= '0;
      sum_q      <= '0;
      peak_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_sum_q  <= acc_sum_d;
      acc_peak_q <= acc_peak_d;
      sum_q      <= sum_d;
      peak_q     <= peak_d;
      drop_q     <= drop_d;
    end
  end

  assign sample_ready_o = (state_q == COLLECT);
  assign result_valid_o = (state_q == RESULT);
  assign busy_o         = (state_q != IDLE);
  assign sum_o          = sum_q;
  assign peak_o         = peak_q;
  assign frame_drop_o   = drop_q;
  assign sample_count_o = count_q;

endmodule

// File: tb/tb_frame_stats.sv
// Directed bench for frame_stats: sums, peaks, boundaries, drops, reset.
module tb_frame_stats;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [35:0] sample;
  logic               svalid;
  logic               sready;
  logic signed [39:0] sum;
  logic [35:0]        peak;
  logic               rvalid;
  logic               rready;
  logic               busy;
  logic               drop;
  logic [4:0]         cnt;

  int n_chk = 0;
  int n_fail = 0;

  frame_stats dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_start_i  (start),
    .sample_i       (sample),
    .sample_valid_i (svalid),
    .sample_ready_o (sready),
    .sum_o          (sum),
    .peak_o         (peak),
    .result_valid_o (rvalid),
    .result_ready_i (rready),
    .busy_o         (busy),
    .frame_drop_o   (drop),
    .sample_count_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept(input logic [35:0] s);
    sample = s;
    svalid = 1'b1;
    tick();
    svalid = 1'b0;
  endtask

  task automatic ramp_frame();
    pulse_start();
    for (int i = 1; i <= 16; i++) accept(36'(i));
  endtask

  task automatic consume();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample = '0; svalid = 1'b0; rready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    svalid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    svalid = 1'b0;
    chk("rst_ready", 64'(sready), 64'd0);
    chk("rst_sum", 64'($unsigned(sum)), 64'd0);
    chk("rst_peak", 64'(peak), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);

    // ramp 1..16
    pulse_start();
    chk("col_ready", 64'(sready), 64'd1);
    chk("col_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 15; i++) accept(36'(i));
    chk("pre_last_rvalid", 64'(rvalid), 64'd0);
    chk("pre_last_cnt", 64'(cnt), 64'd15);
    accept(36'd16);
    chk("ramp_rvalid", 64'(rvalid), 64'd1);
    chk("ramp_sum", 64'($unsigned(sum)), 64'd136);
    chk("ramp_peak", 64'(peak), 64'd16);
    chk("ramp_cnt", 64'(cnt), 64'd16);
    chk("res_ready", 64'(sready), 64'd0);
    consume();
    chk("cons_rvalid", 64'(rvalid), 64'd0);
    chk("cons_busy", 64'(busy), 64'd0);
    chk("cons_cnt", 64'(cnt), 64'd0);
    chk("cons_sum_hold", 64'($unsigned(sum)), 64'd136);

    // most negative sample, gapped valid
    pulse_start();
    accept(36'h8_0000_0000);
    tick(); tick();
    chk("gap_cnt", 64'(cnt), 64'd1);
    chk("gap_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 15; i++) begin
      accept(36'd0);
      tick();
    end
    chk("neg_rvalid", 64'(rvalid), 64'd1);
    chk("neg_sum", 64'($unsigned(sum)), 64'h00F8_0000_0000);
    chk("neg_peak", 64'(peak), 64'h8_0000_0000);
    consume();

    // full-scale positive, with a drop while collecting
    pulse_start();
    accept(36'h7_FFFF_FFFF);
    start = 1'b1;
    accept(36'h7_FFFF_FFFF);
    start = 1'b0;
    chk("col_drop", 64'(drop), 64'd1);
    accept(36'h7_FFFF_FFFF);
    chk("col_drop_end", 64'(drop), 64'd0);
    for (int i = 3; i < 16; i++) accept(36'h7_FFFF_FFFF);
    chk("pos_sum", 64'($unsigned(sum)), 64'h007F_FFFF_FFF0);
    chk("pos_peak", 64'(peak), 64'h7_FFFF_FFFF);
    chk("pos_cnt", 64'(cnt), 64'd16);

    // held result with a start pulse during stall
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_drop", 64'(drop), 64'd1);
    tick();
    chk("hold_drop_end", 64'(drop), 64'd0);
    tick(); tick();
    chk("hold_rvalid", 64'(rvalid), 64'd1);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_sum", 64'($unsigned(sum)), 64'h007F_FFFF_FFF0);
    chk("hold_peak", 64'(peak), 64'h7_FFFF_FFFF);
    consume();
    chk("hold_idle", 64'(busy), 64'd0);
    chk("hold_cnt", 64'(cnt), 64'd0);

    // start coincident with consume
    ramp_frame();
    start = 1'b1;
    rready = 1'b1;
    tick();
    start = 1'b0;
    rready = 1'b0;
    chk("coinc_drop", 64'(drop), 64'd1);
    chk("coinc_busy", 64'(busy), 64'd0);
    chk("coinc_rvalid", 64'(rvalid), 64'd0);

    // reset mid-frame
    pulse_start();
    for (int i = 0; i < 7; i++) accept(36'h1_0000_0000);
    chk("mid_cnt", 64'(cnt), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cnt", 64'(cnt), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_sum", 64'($unsigned(sum)), 64'd0);
    ramp_frame();
    chk("post_sum", 64'($unsigned(sum)), 64'd136);
    chk("post_peak", 64'(peak), 64'd16);
    chk("post_rvalid", 64'(rvalid), 64'd1);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
